// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC sample scheduler and its sample FIFO.
package dac_pkg;

   localparam int unsigned      DAC_W        = 8;
   localparam logic [DAC_W-1:0] DAC_MIDSCALE = 8'h80;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StRun
   } sched_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Small synchronous sample FIFO; pointers carry one extra wrap bit for full/empty.
module dac_sample_fifo
   import dac_pkg::*;
#(
   parameter int unsigned FIFO_AW = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [DAC_W-1:0] i_data,
   input  logic             i_pop,
   output logic [DAC_W-1:0] o_head,
   output logic             o_full,
   output logic             o_empty,
   output logic [FIFO_AW:0] o_level
);

   localparam int unsigned      Depth  = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] PtrOne = (FIFO_AW + 1)'(1);

   logic [DAC_W-1:0] r_mem [Depth];
   logic [FIFO_AW:0] r_wr_ptr;
   logic [FIFO_AW:0] r_rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + PtrOne;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrOne;
         end
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) begin
         r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_data;
      end
   end

   assign o_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                    (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
   assign o_level = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/dac_sample_scheduler.sv
// Buffers audio samples and presents one DAC input word every 2^OSR_LOG2 clocks.
// Optional sticky underrun counter (underrun_cnt port): define DAC_SCHED_UNDERRUN_CNT_EN.
module dac_sample_scheduler
   import dac_pkg::*;
#(
   parameter int unsigned OSR_LOG2   = 10,
   parameter int unsigned FIFO_AW    = 2,
   parameter int unsigned FILL_LEVEL = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             mute,
   input  logic             s_valid,
   input  logic [DAC_W-1:0] s_data,
   output logic             s_ready,
   input  logic             clear_underrun,
   output logic [DAC_W-1:0] dac_din,
   output logic             sample_tick,
   output logic             underrun,
   output logic [FIFO_AW:0] fifo_level
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
   ,
   output logic [15:0]      underrun_cnt
`endif
);

   localparam logic [OSR_LOG2-1:0] OsrMax  = '1;
   localparam logic [OSR_LOG2-1:0] OsrOne  = OSR_LOG2'(1);
   localparam logic [FIFO_AW:0]    FillLvl = (FIFO_AW + 1)'(FILL_LEVEL);

   sched_state_e        r_state;
   logic [OSR_LOG2-1:0] r_osr_cnt;
   logic [DAC_W-1:0]    r_dac_din;
   logic                r_tick;
   logic                r_underrun;

   logic             w_full;
   logic             w_empty;
   logic [DAC_W-1:0] w_head;
   logic [FIFO_AW:0] w_level;
   logic             w_push;
   logic             w_pop;
   logic             w_tick;
   logic             w_underrun_set;

   assign s_ready        = enable && !w_full;
   assign w_push         = s_valid && s_ready;
   assign w_tick         = enable && (r_state == StRun) && (r_osr_cnt == OsrMax);
   // A same-cycle push is invisible to the pop: an empty tick is an underrun.
   assign w_pop          = w_tick && !w_empty;
   assign w_underrun_set = w_tick && w_empty;

   dac_sample_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (!enable),
      .i_push  (w_push),
      .i_data  (s_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StIdle;
         r_osr_cnt <= '0;
         r_dac_din <= DAC_MIDSCALE;
         r_tick    <= 1'b0;
      end else if (!enable) begin
         r_state   <= StIdle;
         r_osr_cnt <= '0;
         r_dac_din <= DAC_MIDSCALE;
         r_tick    <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         case (r_state)
            StIdle: begin
               r_state   <= StFill;
               r_osr_cnt <= '0;
            end
            StFill: begin
               if (w_level >= FillLvl) begin
                  r_state   <= StRun;
                  r_osr_cnt <= OsrMax;
               end
            end
            StRun: begin
               r_osr_cnt <= r_osr_cnt + OsrOne;
               if (w_tick) begin
                  r_tick <= 1'b1;
                  if (mute) begin
                     r_dac_din <= DAC_MIDSCALE;
                  end else if (!w_empty) begin
                     r_dac_din <= w_head;
                  end
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   // Sticky flag survives disable; a new underrun beats a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underrun <= 1'b0;
      end else if (w_underrun_set) begin
         r_underrun <= 1'b1;
      end else if (clear_underrun) begin
         r_underrun <= 1'b0;
      end
   end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
   logic [15:0] r_underrun_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_underrun_cnt <= '0;
      end else if (w_underrun_set) begin
         r_underrun_cnt <= sat_inc16(r_underrun_cnt);
      end else if (clear_underrun) begin
         r_underrun_cnt <= '0;
      end
   end

   assign underrun_cnt = r_underrun_cnt;
`endif

   assign dac_din     = r_dac_din;
   assign sample_tick = r_tick;
   assign underrun    = r_underrun;
   assign fifo_level  = w_level;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Randomised bench for dac_sample_scheduler against a queue-and-timestamp reference model.
module tb_dac_sample_scheduler;

   localparam int unsigned OsrLog2 = 2;
   localparam int unsigned FifoAw  = 2;
   localparam int unsigned FillLvl = 4;
   localparam int          Period  = 1 << OsrLog2;
   localparam int          Depth   = 1 << FifoAw;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       mute;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       clear_underrun;
   logic [7:0] dac_din;
   logic       sample_tick;
   logic       underrun;
   logic [2:0] fifo_level;
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   dac_sample_scheduler #(
      .OSR_LOG2   (OsrLog2),
      .FIFO_AW    (FifoAw),
      .FILL_LEVEL (FillLvl)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .mute           (mute),
      .s_valid        (s_valid),
      .s_data         (s_data),
      .s_ready        (s_ready),
      .clear_underrun (clear_underrun),
      .dac_din        (dac_din),
      .sample_tick    (sample_tick),
      .underrun       (underrun),
      .fifo_level     (fifo_level)
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
      ,
      .underrun_cnt   (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: sample queue plus absolute cycle number of the next tick.
   logic [7:0] mq[$];
   int         mode;          // 0 idle, 1 filling, 2 playing
   longint     cyc = 0;
   longint     next_tick = 0;
   logic [7:0] m_din;
   bit         m_tick;
   bit         m_unr;
   int         m_cnt;

   task automatic model_reset();
      mq.delete();
      mode   = 0;
      m_din  = 8'h80;
      m_tick = 1'b0;
      m_unr  = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic model_step();
      int         lvl;
      bit         rdy;
      bit         set;
      logic [7:0] h;
      lvl    = mq.size();
      rdy    = enable && (lvl < Depth);
      set    = 1'b0;
      m_tick = 1'b0;
      if (!enable) begin
         mode  = 0;
         mq.delete();
         m_din = 8'h80;
      end else begin
         if (mode == 2 && cyc == next_tick) begin
            m_tick    = 1'b1;
            next_tick = cyc + Period;
            if (lvl > 0) begin
               h     = mq.pop_front();
               m_din = mute ? 8'h80 : h;
            end else begin
               set = 1'b1;
               if (mute) m_din = 8'h80;
            end
         end else if (mode == 1 && lvl >= FillLvl) begin
            mode      = 2;
            next_tick = cyc + 1;
         end else if (mode == 0) begin
            mode = 1;
         end
         if (s_valid && rdy) mq.push_back(s_data);
      end
      if (set) begin
         m_unr = 1'b1;
         if (m_cnt < 65535) m_cnt++;
      end else if (clear_underrun) begin
         m_unr = 1'b0;
         m_cnt = 0;
      end
   endtask

   // Compare process: step the model on every edge, check all outputs just after it.
   always @(posedge clk) begin
      cyc++;
      if (rst) model_reset();
      else model_step();
      #1;
      if (!rst) begin
         chk("dac_din", 32'(dac_din), 32'(m_din));
         chk("sample_tick", 32'(sample_tick), 32'(m_tick));
         chk("underrun", 32'(underrun), 32'(m_unr));
         chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
         chk("s_ready", 32'(s_ready), 32'(enable && (mq.size() < Depth)));
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
         chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
`endif
      end
   end

   task automatic wait_tick(output int gap);
      gap = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (sample_tick) begin
            gap = i;
            return;
         end
      end
      n_vec++;
      n_err++;
      $display("FAIL tick_timeout: got no sample_tick, expected one within 20 cycles at %0t", $time);
   endtask

   int g;

   initial begin
      rst            = 1'b1;
      enable         = 1'b0;
      mute           = 1'b0;
      s_valid        = 1'b1;
      s_data         = 8'h33;
      clear_underrun = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Idle with a sample offered: nothing accepted, midscale output.
      repeat (3) @(posedge clk);
      #1;
      chk("idle_s_ready", 32'(s_ready), 32'h0);
      chk("idle_dac_din", 32'(dac_din), 32'h80);
      chk("idle_level", 32'(fifo_level), 32'h0);
      chk("idle_tick", 32'(sample_tick), 32'h0);

      // Fill and play four samples.
      @(negedge clk);
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = 8'((i + 1) * 16);
         @(negedge clk);
      end
      s_valid = 1'b0;
      wait_tick(g);
      chk("first_gap", 32'(g), 32'd2);
      chk("first_sample", 32'(dac_din), 32'h10);
      for (int i = 2; i <= 4; i++) begin
         wait_tick(g);
         chk("play_gap", 32'(g), 32'd4);
         chk("play_sample", 32'(dac_din), 32'(i * 16));
      end

      // Fifth tick finds the FIFO empty.
      wait_tick(g);
      chk("underrun_gap", 32'(g), 32'd4);
      chk("underrun_hold", 32'(dac_din), 32'h40);
      chk("underrun_flag", 32'(underrun), 32'h1);
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
      chk("underrun_cnt_one", 32'(underrun_cnt), 32'd1);
`endif
      @(negedge clk);
      clear_underrun = 1'b1;
      @(negedge clk);
      clear_underrun = 1'b0;
      chk("underrun_cleared", 32'(underrun), 32'h0);
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
      chk("underrun_cnt_cleared", 32'(underrun_cnt), 32'd0);
`endif

      // Backpressure: keep offering until full, then watch a tick free one slot.
      s_valid = 1'b1;
      s_data  = 8'h5A;
      repeat (16) @(negedge clk);
      wait_tick(g);
      chk("bp_tick_level", 32'(fifo_level), 32'd3);
      chk("bp_tick_ready", 32'(s_ready), 32'h1);
      chk("bp_tick_sample", 32'(dac_din), 32'h5A);
      @(posedge clk);
      #1;
      chk("bp_refill_level", 32'(fifo_level), 32'd4);
      chk("bp_full_ready", 32'(s_ready), 32'h0);

      // Mute between ticks: no change until the next tick, FIFO still drains.
      @(negedge clk);
      s_valid = 1'b0;
      mute    = 1'b1;
      @(posedge clk);
      #1;
      chk("mute_between", 32'(dac_din), 32'h5A);
      wait_tick(g);
      chk("mute_tick_dac", 32'(dac_din), 32'h80);
      chk("mute_tick_level", 32'(fifo_level), 32'd3);
      @(negedge clk);
      mute = 1'b0;
      wait_tick(g);
      chk("unmute_dac", 32'(dac_din), 32'h5A);
      chk("unmute_level", 32'(fifo_level), 32'd2);

      // Disable with three entries queued and a push offered.
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'h77;
      @(negedge clk);
      chk("pre_disable_level", 32'(fifo_level), 32'd3);
      enable = 1'b0;
      s_data = 8'hEE;
      @(posedge clk);
      #1;
      chk("disable_level", 32'(fifo_level), 32'd0);
      chk("disable_dac", 32'(dac_din), 32'h80);
      chk("disable_ready", 32'(s_ready), 32'h0);

      // Random traffic; the compare process checks every cycle.
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         enable         = ($urandom_range(39) != 0);
         s_valid        = $urandom_range(1);
         s_data         = 8'($urandom);
         clear_underrun = ($urandom_range(9) == 0);
         if ($urandom_range(15) == 0) mute = ~mute;
      end

      // Drive into a guaranteed underrun, then reset asynchronously mid-period.
      @(negedge clk);
      enable         = 1'b1;
      mute           = 1'b0;
      clear_underrun = 1'b0;
      s_valid        = 1'b1;
      s_data         = 8'hA5;
      repeat (6) @(negedge clk);
      s_valid = 1'b0;
      repeat (40) @(negedge clk);
      chk("pre_reset_underrun", 32'(underrun), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_dac", 32'(dac_din), 32'h80);
      chk("async_rst_tick", 32'(sample_tick), 32'h0);
      chk("async_rst_underrun", 32'(underrun), 32'h0);
      chk("async_rst_level", 32'(fifo_level), 32'h0);
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
      chk("async_rst_cnt", 32'(underrun_cnt), 32'h0);
`endif
      @(negedge clk);
      rst     = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'h3C;
      repeat (30) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
